// File: rtl/stack_pkg.sv
// Shared opcode encoding and sizing helpers for the LIFO stack.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: synchronous write port, combinational read port.
// Contents are deliberately not reset; stale words are unreachable because
// the read address is always derived from the live occupancy count.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed word into the slot just above the current top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The top-of-stack word is always visible for POP/PEEK.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/stack.sv
// LIFO stack top level: opcode decode, occupancy count, registered
// data_out/error, and full/empty flags decoded from the registered count.
module stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       instruction,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             error
);

  logic             push_ok;
  logic             pop_ok;
  logic             peek_ok;
  logic             illegal;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] top_word;

  // Flags depend only on the registered count, so they never glitch.
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
  end

  // Decode the opcode into legal actions and the illegal-operation flag.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    peek_ok = 1'b0;
    illegal = 1'b0;
    case (instruction)
      OP_PUSH: begin
        push_ok = !full;
        illegal = full;
      end
      OP_POP: begin
        pop_ok  = !empty;
        illegal = empty;
      end
      OP_PEEK: begin
        peek_ok = !empty;
        illegal = empty;
      end
      default: begin
      end
    endcase
  end

  // Write slot is index count, top of stack is index count-1; both are
  // truncated to the array address width (the write slot is never used
  // when full, and the read slot is never used when empty).
  always_comb begin
    waddr = AW'(count);
    raddr = AW'(count - CW'(1));
  end

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (top_word)
  );

  // Occupancy counter: saturation is implied by the guarded push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push_ok) begin
      count <= count + CW'(1);
    end else if (pop_ok) begin
      count <= count - CW'(1);
    end
  end

  // Capture the top word on a legal POP or PEEK; hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (pop_ok || peek_ok) begin
      data_out <= top_word;
    end
  end

  // One-cycle pulse for the operation just sampled being illegal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= illegal;
    end
  end

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for the stack: directed scenarios followed by biased
// random operations, all compared against a queue-based LIFO model.
module tb_stack;
  import stack_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic [1:0]       instruction;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             error;

  int total = 0;
  int bad   = 0;

  // Reference model: expected stack contents, last read word, error pulse.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_err;

  stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .data_in     (data_in),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .error       (error)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    check({tag, ".count"},    32'(count),    32'(exp_q.size()));
    check({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
    check({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
    check({tag, ".error"},    32'(error),    32'(m_err));
  endtask

  // LIFO rules applied to one sampled operation.
  task automatic model_step(input logic [1:0] op, input logic [WIDTH-1:0] d);
    case (op)
      OP_PUSH: begin
        if (exp_q.size() == DEPTH) m_err = 1'b1;
        else begin
          exp_q.push_back(d);
          m_err = 1'b0;
        end
      end
      OP_POP: begin
        if (exp_q.size() == 0) m_err = 1'b1;
        else begin
          m_dout = exp_q.pop_back();
          m_err  = 1'b0;
        end
      end
      OP_PEEK: begin
        if (exp_q.size() == 0) m_err = 1'b1;
        else begin
          m_dout = exp_q[$];
          m_err  = 1'b0;
        end
      end
      default: m_err = 1'b0;
    endcase
  endtask

  // Driver: present one opcode, let one edge sample it, then compare.
  task automatic drive(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] d);
    @(negedge clk);
    instruction = op;
    data_in     = d;
    @(posedge clk);
    #1;
    model_step(op, d);
    check_all(tag);
  endtask

  // Full reset: outputs must clear while held, even with an active opcode.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset       = 1'b1;
    instruction = OP_PUSH;
    data_in     = 8'hA5;
    #1;
    exp_q.delete();
    m_dout = '0;
    m_err  = 1'b0;
    check_all({tag, ".during"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    instruction = OP_NOP;
    reset       = 1'b0;
  endtask

  initial begin
    int r;
    int mode;
    logic [1:0] op;
    reset       = 1'b1;
    instruction = OP_NOP;
    data_in     = '0;
    m_dout      = '0;
    m_err       = 1'b0;
    do_reset("init");

    // Push, push, peek, pop
    drive("s1.push10", OP_PUSH, 8'd10);
    drive("s1.push20", OP_PUSH, 8'd20);
    drive("s1.peek",   OP_PEEK, 8'd0);
    check("s1.peek_val", 32'(data_out), 32'd20);
    drive("s1.pop",    OP_POP,  8'd0);
    check("s1.pop_val", 32'(data_out), 32'd20);
    check("s1.pop_cnt", 32'(count), 32'd1);

    // Pop from empty, then the error pulse must drop after a NOP
    do_reset("s2.rst");
    drive("s2.pop_empty", OP_POP, 8'd0);
    check("s2.err_pulse", 32'(error), 32'd1);
    drive("s2.nop", OP_NOP, 8'd0);
    check("s2.err_clear", 32'(error), 32'd0);

    // Fill, overflow attempt, drain
    do_reset("s3.rst");
    for (int i = 1; i <= DEPTH; i++) drive("s3.fill", OP_PUSH, WIDTH'(i));
    check("s3.full", 32'(full), 32'd1);
    drive("s3.overflow", OP_PUSH, 8'd99);
    check("s3.ovf_err", 32'(error), 32'd1);
    check("s3.ovf_cnt", 32'(count), 32'(DEPTH));
    for (int i = DEPTH; i >= 1; i--) begin
      drive("s3.drain", OP_POP, 8'd0);
      check("s3.drain_val", 32'(data_out), 32'(i));
    end
    check("s3.empty", 32'(empty), 32'd1);
    drive("s3.underflow", OP_POP, 8'd0);

    // NOPs hold state
    do_reset("s4.rst");
    drive("s4.push5", OP_PUSH, 8'd5);
    for (int i = 0; i < 3; i++) drive("s4.nop", OP_NOP, 8'd77);
    drive("s4.peek", OP_PEEK, 8'd0);
    check("s4.peek_val", 32'(data_out), 32'd5);

    // Reset asserted between edges, then stale memory must be unreachable
    do_reset("s5.rst");
    drive("s5.push7", OP_PUSH, 8'd7);
    drive("s5.push9", OP_PUSH, 8'd9);
    drive("s5.peek",  OP_PEEK, 8'd0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_dout = '0;
    m_err  = 1'b0;
    check_all("s5.async");
    @(negedge clk);
    instruction = OP_NOP;
    reset       = 1'b0;
    drive("s5.peek_after", OP_PEEK, 8'd0);
    check("s5.peek_err", 32'(error), 32'd1);
    check("s5.peek_dout", 32'(data_out), 32'd0);

    // Biased random traffic, alternating fill-heavy and drain-heavy phases
    do_reset("rnd.rst");
    for (int i = 0; i < 600; i++) begin
      mode = (i / 40) % 2;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset("rnd.reset");
      end else begin
        r = int'($urandom_range(0, 99));
        if (mode == 0) op = (r < 55) ? OP_PUSH : (r < 75) ? OP_POP : (r < 90) ? OP_PEEK : OP_NOP;
        else           op = (r < 20) ? OP_PUSH : (r < 70) ? OP_POP : (r < 88) ? OP_PEEK : OP_NOP;
        drive("rnd", op, WIDTH'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of stack entries (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction  input  2  opcode sampled each rising clk edge: 00 PUSH, 01 POP, 10 PEEK, 11 NOP.
REQ-006 data_in  input  WIDTH  word written on PUSH.
REQ-007 data_out  output  WIDTH  registered result of the last successful POP or PEEK.
REQ-008 empty  output  1  high when the stack holds 0 entries.
REQ-009 full  output  1  high when the stack holds DEPTH entries.
REQ-010 count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-011 error  output  1  registered one-cycle pulse flagging an illegal operation.

Function
REQ-012 The stack SHALL be LIFO, storing entries in a DEPTH x WIDTH array addressed by count, with the top at index count-1.
REQ-013 A PUSH with full low SHALL write data_in to index count and increment count at the same edge, leaving data_out unchanged.
REQ-014 A PUSH with full high SHALL leave memory, count and data_out unchanged and assert error for the next cycle.
REQ-015 A POP with empty low SHALL load data_out with the top entry and decrement count at the same edge.
REQ-016 A POP with empty high SHALL leave count and data_out unchanged and assert error for the next cycle.
REQ-017 A PEEK with empty low SHALL load data_out with the top entry without changing count.
REQ-018 A PEEK with empty high SHALL leave data_out unchanged and assert error for the next cycle.
REQ-019 A NOP SHALL change no state except deasserting error.
REQ-020 error SHALL be low in every cycle following a legal operation or NOP.
REQ-021 Latency: data_out SHALL show the POP/PEEK result immediately after the sampling edge, i.e. one-cycle latency.
REQ-022 empty and full SHALL be decoded combinationally from registered count only, and are therefore glitch-free relative to clk.
REQ-023 count SHALL never exceed DEPTH or go below 0; no wrap-around SHALL occur.
REQ-024 data_out SHALL hold its value across PUSH, NOP and illegal operations.

Reset
REQ-025 While reset is high, count, data_out and error SHALL be 0 and empty SHALL be 1, regardless of clk or instruction (including unknown values).
REQ-026 Reset asserted mid-operation SHALL abort it immediately, and the stack SHALL restart empty at the first edge after deassertion.
REQ-027 Memory contents SHALL NOT be reset, and SHALL be unreachable until rewritten by PUSH.

Structure
REQ-028 Opcode constants (OP_PUSH, OP_POP, OP_PEEK, OP_NOP) SHALL live in a shared package stack_pkg.
REQ-029 Storage SHALL be a sub-module stack_mem with a synchronous write port and a combinational read port at address count-1.
REQ-030 The top level SHALL contain the count register, opcode decode, data_out and error registers, and flag logic.

Verification
REQ-031 Reset, then PUSH 10, PUSH 20, PEEK -> data_out=20, count=2; then POP -> data_out=20, count=1.
REQ-032 From reset, POP -> error pulses for one cycle, data_out=0, count=0, empty=1.
REQ-033 PUSH 1..8 -> full=1 after the 8th push; a 9th PUSH of 99 -> error pulses and count stays 8; 8 POPs -> data_out 8,7,...,1, then empty=1.
REQ-034 PUSH 5, NOP x3 -> data_out unchanged, count=1, error=0; PEEK -> data_out=5.
REQ-035 PUSH 7, PUSH 9, assert reset between edges -> count=0, empty=1 immediately; after release, PEEK -> error pulses and data_out=0.
